// File: rtl/palette_pkg.sv
// palette_pkg: shared types and constants for the palette mixer.
// Holds the CPU register-select encoding, the bus sequencer states and the
// width of each layer's priority field.
package palette_pkg;

   // Width of one layer priority field in layer_pri.
   localparam int PRI_W = 2;

   // CPU register select (va) decoding.
   typedef enum logic [1:0] {
      VA_ADDR = 2'd0,   // CPU palette address
      VA_DATA = 2'd1,   // palette RAM data port
      VA_CTRL = 2'd2,   // write leaves CPU mode
      VA_NOP  = 2'd3    // acknowledge only
   } va_reg_e;

   // CPU bus sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,  // waiting for a falling edge of cs_n
      ST_WR_ACK  = 3'd1,  // write strobe issued, acknowledge next
      ST_RD_ADDR = 3'd2,  // CPU address presented to the RAM
      ST_RD_ACK  = 3'd3,  // read data captured, acknowledge next
      ST_HOLD    = 3'd4   // acknowledged, wait for cs_n to rise
   } bus_state_e;

endpackage

// File: rtl/layer_priority_mux.sv
// layer_priority_mux: picks the colour index of the winning layer.
// A layer is opaque when any of its low TRANSP_BITS index bits is set. Among
// opaque layers the highest priority wins, ties go to the higher layer number,
// and layer 0's index is passed through when every layer is transparent.
module layer_priority_mux
   import palette_pkg::*;
#(
   parameter int N_LAYERS    = 2,
   parameter int IDX_W       = 15,
   parameter int TRANSP_BITS = 4
) (
   input  logic [N_LAYERS*IDX_W-1:0] layer_idx_i,
   input  logic [N_LAYERS*PRI_W-1:0] layer_pri_i,
   output logic [IDX_W-1:0]          sel_idx_o
);

   logic [PRI_W-1:0] best_pri_s;
   logic             found_s;

   // Scan layers upward so that ">=" hands ties to the higher layer number.
   always_comb begin
      sel_idx_o  = layer_idx_i[IDX_W-1:0];
      best_pri_s = '0;
      found_s    = 1'b0;
      for (int i = 0; i < N_LAYERS; i++) begin
         if ((|layer_idx_i[i*IDX_W +: TRANSP_BITS]) &&
             (!found_s || (layer_pri_i[i*PRI_W +: PRI_W] >= best_pri_s))) begin
            sel_idx_o  = layer_idx_i[i*IDX_W +: IDX_W];
            best_pri_s = layer_pri_i[i*PRI_W +: PRI_W];
            found_s    = 1'b1;
         end else begin
            found_s    = found_s;
         end
      end
   end

endmodule

// File: rtl/palette_mixer.sv
// palette_mixer: CPU port onto an external palette RAM plus a two-stage
// layer mixer (stage 1 picks the layer index, stage 2 loads the RAM word).
// Optional feature: define PALETTE_AUTOINC_EN to advance the CPU address by
// one after every va=1 RAM cycle; otherwise only va=0 writes change it.
module palette_mixer
   import palette_pkg::*;
#(
   parameter int N_LAYERS    = 2,
   parameter int IDX_W       = 15,
   parameter int PAL_AW      = 13,
   parameter int PAL_DW      = 16,
   parameter int TRANSP_BITS = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ce_pixel,
   input  logic [15:0]               din,
   output logic [15:0]               dout,
   input  logic [1:0]                va,
   input  logic                      rw_n,
   input  logic                      uds_n,
   input  logic                      lds_n,
   input  logic                      cs_n,
   output logic                      dtack_n,
   input  logic [N_LAYERS*IDX_W-1:0] layer_idx,
   input  logic [N_LAYERS*PRI_W-1:0] layer_pri,
   input  logic                      hsync_n,
   input  logic                      vsync_n,
   output logic                      hsync_out_n,
   output logic                      vsync_out_n,
   output logic [PAL_AW-1:0]         pal_addr,
   input  logic [PAL_DW-1:0]         pal_din,
   output logic [PAL_DW-1:0]         pal_dout,
   output logic                      pal_we_l_n,
   output logic                      pal_we_h_n,
   output logic [PAL_DW-1:0]         rgb_out
);

   bus_state_e        state_q, state_d;
   logic              cs_q;
   logic              cpu_mode_q, cpu_mode_d;
   logic [PAL_AW-1:0] cpu_addr_q, cpu_addr_d, cpu_addr_next_s;
   logic [15:0]       dout_q, dout_d;
   logic              dtack_q, dtack_d;
   logic              we_l_q, we_l_d, we_h_q, we_h_d;
   logic [PAL_DW-1:0] pal_dout_q, pal_dout_d;
   logic [PAL_AW-1:0] pix_addr_q, pix_addr_s;
   logic              pix_valid_q;
   logic [PAL_DW-1:0] rgb_q;
   logic [1:0]        hs_q, vs_q;
   logic [IDX_W-1:0]  sel_idx_s;
   logic              access_start_s;
   va_reg_e           va_s;
   logic [15:0]       addr_ext_s, addr_wr_s;

   assign access_start_s = cs_q & ~cs_n;
   assign va_s           = va_reg_e'(va);
   assign addr_ext_s     = 16'(cpu_addr_q);
   assign addr_wr_s      = {uds_n ? addr_ext_s[15:8] : din[15:8],
                            lds_n ? addr_ext_s[7:0]  : din[7:0]};

`ifdef PALETTE_AUTOINC_EN
   assign cpu_addr_next_s = cpu_addr_q + {{(PAL_AW-1){1'b0}}, 1'b1};
`else
   assign cpu_addr_next_s = cpu_addr_q;
`endif

   layer_priority_mux #(
      .N_LAYERS    (N_LAYERS),
      .IDX_W       (IDX_W),
      .TRANSP_BITS (TRANSP_BITS)
   ) u_pri_mux (
      .layer_idx_i (layer_idx),
      .layer_pri_i (layer_pri),
      .sel_idx_o   (sel_idx_s)
   );

   assign pix_addr_s = PAL_AW'({sel_idx_s, 1'b0});

   // Bus sequencer: decode an access once per cs_n fall and walk its RAM cycle.
   always_comb begin
      state_d    = state_q;
      cpu_mode_d = cpu_mode_q;
      cpu_addr_d = cpu_addr_q;
      dout_d     = dout_q;
      dtack_d    = dtack_q;
      we_l_d     = 1'b1;
      we_h_d     = 1'b1;
      pal_dout_d = pal_dout_q;
      case (state_q)
         ST_IDLE: begin
            dtack_d = 1'b1;
            if (access_start_s) begin
               case (va_s)
                  VA_ADDR: begin
                     if (!rw_n) begin
                        cpu_addr_d = addr_wr_s[PAL_AW-1:0];
                        cpu_mode_d = 1'b1;
                     end else begin
                        dout_d     = addr_ext_s;
                     end
                     dtack_d = 1'b0;
                     state_d = ST_HOLD;
                  end
                  VA_DATA: begin
                     if (!rw_n) begin
                        we_h_d     = uds_n;
                        we_l_d     = lds_n;
                        cpu_mode_d = 1'b1;
                        pal_dout_d = PAL_DW'(din);
                        state_d    = ST_WR_ACK;
                     end else begin
                        state_d    = ST_RD_ADDR;
                     end
                  end
                  VA_CTRL: begin
                     if (!rw_n) begin
                        cpu_mode_d = 1'b0;
                     end else begin
                        cpu_mode_d = cpu_mode_q;
                     end
                     dtack_d = 1'b0;
                     state_d = ST_HOLD;
                  end
                  default: begin
                     dtack_d = 1'b0;
                     state_d = ST_HOLD;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_ACK: begin
            dtack_d    = 1'b0;
            cpu_addr_d = cpu_addr_next_s;
            state_d    = ST_HOLD;
         end
         ST_RD_ADDR: begin
            dout_d     = 16'(pal_din);
            cpu_addr_d = cpu_addr_next_s;
            state_d    = ST_RD_ACK;
         end
         ST_RD_ACK: begin
            dtack_d = 1'b0;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cs_n) begin
               dtack_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            dtack_d = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus registers; reset also clears cs_q so a cs_n held low is not an edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cs_q       <= 1'b0;
         cpu_mode_q <= 1'b0;
         cpu_addr_q <= '0;
         dout_q     <= 16'h0000;
         dtack_q    <= 1'b1;
         we_l_q     <= 1'b1;
         we_h_q     <= 1'b1;
         pal_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         cs_q       <= cs_n;
         cpu_mode_q <= cpu_mode_d;
         cpu_addr_q <= cpu_addr_d;
         dout_q     <= dout_d;
         dtack_q    <= dtack_d;
         we_l_q     <= we_l_d;
         we_h_q     <= we_h_d;
         pal_dout_q <= pal_dout_d;
      end
   end

   // Pixel pipeline; pix_valid_q blanks the first output after CPU mode ends.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pix_addr_q  <= '0;
         pix_valid_q <= 1'b0;
         rgb_q       <= '0;
         hs_q        <= 2'b11;
         vs_q        <= 2'b11;
      end else if (ce_pixel) begin
         pix_addr_q  <= pix_addr_s;
         pix_valid_q <= ~cpu_mode_q;
         rgb_q       <= (cpu_mode_q || !pix_valid_q) ? '0 : pal_din;
         hs_q        <= {hs_q[0], hsync_n};
         vs_q        <= {vs_q[0], vsync_n};
      end else begin
         pix_addr_q  <= pix_addr_q;
         pix_valid_q <= pix_valid_q;
         rgb_q       <= rgb_q;
         hs_q        <= hs_q;
         vs_q        <= vs_q;
      end
   end

   // A read holds the RAM on the CPU address for its one-cycle RAM slot.
   assign pal_addr    = (cpu_mode_q || (state_q == ST_RD_ADDR)) ? cpu_addr_q : pix_addr_q;
   assign pal_dout    = pal_dout_q;
   assign pal_we_l_n  = we_l_q;
   assign pal_we_h_n  = we_h_q;
   assign dout        = dout_q;
   // cs_n high forces dtack_n high at once rather than a cycle later.
   assign dtack_n     = dtack_q | cs_n;
   assign rgb_out     = rgb_q;
   assign hsync_out_n = hs_q[1];
   assign vsync_out_n = vs_q[1];

endmodule

// File: tb/tb_palette_mixer.sv
// tb_palette_mixer: self-checking bench for palette_mixer with a behavioural
// palette RAM and a reference model of layer selection and pixel timing.
// Honours PALETTE_AUTOINC_EN in its CPU-address model.
module tb_palette_mixer;

   localparam int N_LAYERS    = 2;
   localparam int IDX_W       = 15;
   localparam int PAL_AW      = 13;
   localparam int PAL_DW      = 16;
   localparam int TRANSP_BITS = 4;

   logic                      clk = 1'b0;
   logic                      reset_n, ce_pixel;
   logic [15:0]               din, dout;
   logic [1:0]                va;
   logic                      rw_n, uds_n, lds_n, cs_n, dtack_n;
   logic [N_LAYERS*IDX_W-1:0] layer_idx;
   logic [N_LAYERS*2-1:0]     layer_pri;
   logic                      hsync_n, vsync_n, hsync_out_n, vsync_out_n;
   logic [PAL_AW-1:0]         pal_addr;
   logic [PAL_DW-1:0]         pal_din, pal_dout, rgb_out;
   logic                      pal_we_l_n, pal_we_h_n;

   logic [PAL_DW-1:0] mem [0:(1<<PAL_AW)-1];

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   logic              cpu_mode_m;
   int                cpu_addr_m;
   int                prev_addr_m;
   logic              prev_valid_m;
   logic              prev_hs_m, prev_vs_m;

   always #5 clk = ~clk;

   palette_mixer #(
      .N_LAYERS(N_LAYERS), .IDX_W(IDX_W), .PAL_AW(PAL_AW),
      .PAL_DW(PAL_DW), .TRANSP_BITS(TRANSP_BITS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
      .din(din), .dout(dout), .va(va),
      .rw_n(rw_n), .uds_n(uds_n), .lds_n(lds_n), .cs_n(cs_n), .dtack_n(dtack_n),
      .layer_idx(layer_idx), .layer_pri(layer_pri),
      .hsync_n(hsync_n), .vsync_n(vsync_n),
      .hsync_out_n(hsync_out_n), .vsync_out_n(vsync_out_n),
      .pal_addr(pal_addr), .pal_din(pal_din), .pal_dout(pal_dout),
      .pal_we_l_n(pal_we_l_n), .pal_we_h_n(pal_we_h_n), .rgb_out(rgb_out)
   );

   // Asynchronous-read palette RAM with byte-lane writes.
   assign pal_din = mem[pal_addr];
   initial begin
      for (int a = 0; a < (1 << PAL_AW); a++) mem[a] <= 16'($urandom);
      mem[0] <= 16'h0000;
      forever begin
         @(posedge clk);
         if (!pal_we_h_n) mem[pal_addr][15:8] <= pal_dout[15:8];
         if (!pal_we_l_n) mem[pal_addr][7:0]  <= pal_dout[7:0];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Winner = largest (priority, layer number) among opaque layers.
   function automatic logic [IDX_W-1:0] model_pick(input logic [N_LAYERS*IDX_W-1:0] idx,
                                                   input logic [N_LAYERS*2-1:0] pri);
      int best_key;
      logic [IDX_W-1:0] pick;
      best_key = -1;
      pick = idx[IDX_W-1:0];
      for (int l = 0; l < N_LAYERS; l++) begin
         int v;
         int key;
         v   = int'(idx[l*IDX_W +: IDX_W]);
         key = int'(pri[l*2 +: 2]) * N_LAYERS + l;
         if (((v % (1 << TRANSP_BITS)) != 0) && (key > best_key)) begin
            best_key = key;
            pick = idx[l*IDX_W +: IDX_W];
         end
      end
      return pick;
   endfunction

   task automatic model_reset();
      cpu_mode_m   = 1'b0;
      cpu_addr_m   = 0;
      prev_addr_m  = 0;
      prev_valid_m = 1'b0;
      prev_hs_m    = 1'b1;
      prev_vs_m    = 1'b1;
   endtask

   task automatic pixel_strobe(input logic [N_LAYERS*IDX_W-1:0] idx,
                               input logic [N_LAYERS*2-1:0] pri,
                               input logic hs, input logic vs, input string tag);
      logic [PAL_DW-1:0] exp_rgb;
      int exp_addr;
      exp_rgb  = (prev_valid_m && !cpu_mode_m) ? mem[prev_addr_m] : '0;
      exp_addr = (int'(model_pick(idx, pri)) * 2) % (1 << PAL_AW);
      layer_idx = idx; layer_pri = pri; hsync_n = hs; vsync_n = vs;
      ce_pixel = 1'b1;
      tick();
      ce_pixel = 1'b0;
      check_eq({tag, "_addr"}, 32'(pal_addr), cpu_mode_m ? 32'(cpu_addr_m) : 32'(exp_addr));
      check_eq({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
      check_eq({tag, "_hs"}, 32'(hsync_out_n), 32'(prev_hs_m));
      check_eq({tag, "_vs"}, 32'(vsync_out_n), 32'(prev_vs_m));
      prev_addr_m  = exp_addr;
      prev_valid_m = !cpu_mode_m;
      prev_hs_m    = hs;
      prev_vs_m    = vs;
   endtask

   // One CPU access; returns read data and cycles until dtack_n went low.
   task automatic cpu_access(input logic [1:0] a_va, input logic a_rw, input logic a_uds,
                             input logic a_lds, input logic [15:0] data, input string tag,
                             output logic [15:0] rdata, output int lat);
      cs_n = 1'b1;
      tick();
      va = a_va; rw_n = a_rw; uds_n = a_uds; lds_n = a_lds; din = data;
      cs_n = 1'b0;
      lat = 0;
      while (dtack_n && lat < 20) begin
         tick();
         lat++;
      end
      check_eq({tag, "_ack"}, 32'(dtack_n), 32'd0);
      rdata = dout;
      cs_n = 1'b1;
      tick();
      check_eq({tag, "_release"}, 32'(dtack_n), 32'd1);
   endtask

   task automatic set_addr(input int a, input string tag);
      logic [15:0] rd;
      int lat;
      cpu_access(2'd0, 1'b0, 1'b0, 1'b0, 16'(a), tag, rd, lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'd1);
      cpu_addr_m = a;
      cpu_mode_m = 1'b1;
   endtask

   // va=1 write observed cycle by cycle; updates the CPU-address model.
   task automatic pal_write(input logic [15:0] data, input logic a_uds, input logic a_lds,
                            input string tag);
      cs_n = 1'b1;
      tick();
      va = 2'd1; rw_n = 1'b0; uds_n = a_uds; lds_n = a_lds; din = data;
      cs_n = 1'b0;
      tick();
      check_eq({tag, "_we"}, {30'd0, pal_we_h_n, pal_we_l_n}, {30'd0, a_uds, a_lds});
      check_eq({tag, "_addr"}, 32'(pal_addr), 32'(cpu_addr_m));
      check_eq({tag, "_dout"}, 32'(pal_dout), 32'(data));
      check_eq({tag, "_early_ack"}, 32'(dtack_n), 32'd1);
      tick();
      check_eq({tag, "_we_end"}, {30'd0, pal_we_h_n, pal_we_l_n}, 32'd3);
      check_eq({tag, "_ack"}, 32'(dtack_n), 32'd0);
      cs_n = 1'b1;
      tick();
      cpu_mode_m = 1'b1;
`ifdef PALETTE_AUTOINC_EN
      cpu_addr_m = (cpu_addr_m + 1) % (1 << PAL_AW);
`endif
   endtask

   task automatic pal_read(input logic [15:0] exp, input string tag);
      logic [15:0] rd;
      int lat;
      cpu_access(2'd1, 1'b1, 1'b0, 1'b0, 16'h0000, tag, rd, lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'd3);
      check_eq({tag, "_data"}, 32'(rd), 32'(exp));
`ifdef PALETTE_AUTOINC_EN
      cpu_addr_m = (cpu_addr_m + 1) % (1 << PAL_AW);
`endif
   endtask

   task automatic random_pixels(input int n);
      for (int k = 0; k < n; k++) begin
         logic [N_LAYERS*IDX_W-1:0] idx;
         logic [N_LAYERS*2-1:0] pri;
         for (int l = 0; l < N_LAYERS; l++) begin
            logic [IDX_W-1:0] v;
            v = IDX_W'($urandom);
            if ($urandom_range(2) == 0) v[TRANSP_BITS-1:0] = '0;
            idx[l*IDX_W +: IDX_W] = v;
         end
         pri = (N_LAYERS*2)'($urandom);
         pixel_strobe(idx, pri, 1'($urandom), 1'($urandom), "rand_px");
         repeat ($urandom_range(2)) tick();
      end
   endtask

   initial begin
      logic [15:0] rd, old_word;
      int lat;
      reset_n = 1'b0; ce_pixel = 1'b0; din = 16'h0000; va = 2'd0;
      rw_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; cs_n = 1'b1;
      layer_idx = '0; layer_pri = '0; hsync_n = 1'b1; vsync_n = 1'b1;
      model_reset();
      repeat (3) tick();
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_dtack", 32'(dtack_n), 32'd1);
      check_eq("rst_we", {30'd0, pal_we_h_n, pal_we_l_n}, 32'd3);
      check_eq("rst_rgb", 32'(rgb_out), 32'd0);
      check_eq("rst_sync", {30'd0, hsync_out_n, vsync_out_n}, 32'd3);
      check_eq("rst_addr", 32'(pal_addr), 32'd0);
      reset_n = 1'b1;
      tick();

      // directed layer selection and two-strobe alignment
      pixel_strobe({15'h0025, 15'h0010}, {2'd1, 2'd3}, 1'b0, 1'b1, "l0_transp");
      pixel_strobe({15'h0025, 15'h0011}, {2'd1, 2'd3}, 1'b1, 1'b0, "pri_l0");
      pixel_strobe({15'h0020, 15'h0010}, {2'd3, 2'd1}, 1'b0, 1'b1, "none_opaque");
      pixel_strobe({15'h0031, 15'h0013}, {2'd2, 2'd2}, 1'b1, 1'b1, "tie_l1");
      pixel_strobe({15'h7FFF, 15'h0001}, {2'd3, 2'd0}, 1'b0, 1'b0, "trunc");
      pixel_strobe({15'h0000, 15'h0000}, {2'd0, 2'd0}, 1'b1, 1'b1, "flush");
      random_pixels(30);

      // CPU mode: address, data write, read-back, byte lanes
      set_addr(16'h0123, "addr_wr");
      cpu_access(2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, "addr_rd", rd, lat);
      check_eq("addr_rd_val", 32'(rd), 32'h0123);
      pal_write(16'hBEEF, 1'b0, 1'b0, "wr_beef");
      cpu_access(2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, "addr_after_wr", rd, lat);
      check_eq("addr_after_wr_val", 32'(rd), 32'(cpu_addr_m));
      set_addr(16'h0123, "addr_wr2");
      pal_read(16'hBEEF, "rd_beef");
      set_addr(16'h0A23, "addr_full");
      cpu_access(2'd0, 1'b0, 1'b1, 1'b0, 16'h5D44, "addr_lo", rd, lat);
      cpu_access(2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, "addr_lane", rd, lat);
      check_eq("addr_lane_val", 32'(rd), 32'h0A44);
      cpu_addr_m = 16'h0A44;
      old_word = mem[16'h0A44];
      pal_write(16'h1234, 1'b1, 1'b0, "wr_lo");
      set_addr(16'h0A44, "addr_wr3");
      pal_read({old_word[15:8], 8'h34}, "rd_lo");

      // pixels while in CPU mode are blanked
      pixel_strobe({15'h0025, 15'h0011}, {2'd1, 2'd3}, 1'b0, 1'b0, "cpu_px0");
      pixel_strobe({15'h0033, 15'h0011}, {2'd0, 2'd0}, 1'b1, 1'b1, "cpu_px1");

      // ack-only registers and leaving CPU mode
      cpu_access(2'd3, 1'b0, 1'b0, 1'b0, 16'hFFFF, "va3", rd, lat);
      check_eq("va3_lat", 32'(lat), 32'd1);
      cpu_access(2'd2, 1'b1, 1'b0, 1'b0, 16'h0000, "va2_rd", rd, lat);
      check_eq("va2_rd_lat", 32'(lat), 32'd1);
      cpu_access(2'd2, 1'b0, 1'b0, 1'b0, 16'h0000, "exit_cpu", rd, lat);
      cpu_mode_m = 1'b0;
      pixel_strobe({15'h0025, 15'h0010}, {2'd1, 2'd3}, 1'b0, 1'b1, "resume1");
      pixel_strobe({15'h0031, 15'h0013}, {2'd2, 2'd2}, 1'b1, 1'b0, "resume2");
      random_pixels(12);

      // reset during an access with cs_n held low
      cs_n = 1'b1;
      tick();
      va = 2'd1; rw_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; din = 16'h0000;
      cs_n = 1'b0; reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("rstacc_we", {30'd0, pal_we_h_n, pal_we_l_n}, 32'd3);
         check_eq("rstacc_dtack", 32'(dtack_n), 32'd1);
      end
      reset_n = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("rel_we", {30'd0, pal_we_h_n, pal_we_l_n}, 32'd3);
         check_eq("rel_dtack", 32'(dtack_n), 32'd1);
      end
      pal_write(16'h0000, 1'b0, 1'b0, "after_toggle");

      // address wrap sequence (fixed address without auto-increment)
      set_addr(16'h1FFF, "addr_top");
      pal_write(16'h1111, 1'b0, 1'b0, "wrap0");
      pal_write(16'h0000, 1'b0, 1'b0, "wrap1");
      pal_write(16'h2222, 1'b0, 1'b0, "wrap2");
      cpu_access(2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, "addr_final", rd, lat);
      check_eq("addr_final_val", 32'(rd), 32'(cpu_addr_m));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
